// File: rtl/console_uart.sv
// console_uart: full-duplex asynchronous console serial port.
// 1 start bit, DATA_BITS data bits LSB first, 1 stop bit, no parity.
// TX and RX each have a small FIFO. RX keeps sticky framing and overrun flags.
//
// Host side handshake: tx_write and rx_read are single-cycle strobes.
// - tx_write takes tx_data only when tx_full is low; a write while full is dropped.
// - rx_read pops the head only when rx_valid is high; a read while empty is ignored.
// - rx_data is the registered head of the RX FIFO. It is valid while rx_valid is high.
module console_uart #(
   parameter int DIVISOR   = 434,
   parameter int DATA_BITS = 8,
   parameter int TX_DEPTH  = 4,
   parameter int RX_DEPTH  = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_write,
   output logic                 tx_full,
   output logic                 tx_idle,
   output logic [DATA_BITS-1:0] rx_data,
   input  logic                 rx_read,
   output logic                 rx_valid,
   output logic                 rx_framing_err,
   output logic                 rx_overrun,
   input  logic                 err_clear,
   input  logic                 console_rxd,
   output logic                 console_txd,
   output logic [1:0]           tx_state_dbg,
   output logic [2:0]           rx_state_dbg
);

   localparam int CW  = $clog2(DIVISOR);
   localparam int BW  = $clog2(DATA_BITS);
   localparam int TAW = $clog2(TX_DEPTH);
   localparam int RAW = $clog2(RX_DEPTH);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START_CHK, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

   // ---------------- TX FIFO ----------------
   logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
   logic [TAW:0]         tx_wr_q, tx_rd_q;
   logic                 tx_empty, tx_push, tx_pop;
   logic [DATA_BITS-1:0] tx_head;

   assign tx_empty = (tx_wr_q == tx_rd_q);
   assign tx_full  = (tx_wr_q[TAW] != tx_rd_q[TAW]) && (tx_wr_q[TAW-1:0] == tx_rd_q[TAW-1:0]);
   assign tx_push  = tx_write && !tx_full;
   assign tx_head  = tx_mem[tx_rd_q[TAW-1:0]];

   // TX FIFO storage; contents need no reset because the pointers qualify them
   always_ff @(posedge clock) begin
      if (tx_push) tx_mem[tx_wr_q[TAW-1:0]] <= tx_data;
   end

   // TX FIFO pointers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tx_wr_q <= '0;
         tx_rd_q <= '0;
      end else begin
         if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
         if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
      end
   end

   // ---------------- TX FSM ----------------
   tx_state_t            tx_state_q, tx_state_d;
   logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
   logic [BW-1:0]        tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
   logic                 txd_q, txd_d;
   logic                 tx_tick;

   assign tx_tick = (tx_cnt_q == CW'(DIVISOR - 1));

   // TX next state: every state lasts DIVISOR cycles. STOP chains straight into START when more data is queued.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_pop     = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_shift_d = tx_head;
               tx_cnt_d   = '0;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            if (tx_tick) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = TX_DATA;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TX_DATA: begin
            if (tx_tick) begin
               tx_cnt_d = '0;
               if (tx_bit_q == BW'(DATA_BITS - 1)) begin
                  tx_state_d = TX_STOP;
               end else begin
                  tx_bit_d   = tx_bit_q + 1'b1;
                  tx_shift_d = tx_shift_q >> 1;
               end
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TX_STOP: begin
            if (tx_tick) begin
               tx_cnt_d = '0;
               if (!tx_empty) begin
                  tx_pop     = 1'b1;
                  tx_shift_d = tx_head;
                  tx_state_d = TX_START;
               end else begin
                  tx_state_d = TX_IDLE;
               end
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
      // Serial output is registered from the next state so the pin never glitches
      case (tx_state_d)
         TX_START: txd_d = 1'b0;
         TX_DATA:  txd_d = tx_shift_d[0];
         default:  txd_d = 1'b1;
      endcase
   end

   // TX state registers; reset forces the line idle high immediately
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         txd_q      <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         txd_q      <= txd_d;
      end
   end

   assign console_txd  = txd_q;
   assign tx_idle      = (tx_state_q == TX_IDLE) && tx_empty;
   assign tx_state_dbg = tx_state_q;

   // ---------------- RX synchroniser ----------------
   logic rxd_s1_q, rxd_s2_q, rxd_prev_q;

   // Two-flop synchroniser plus one delayed copy for falling-edge detection
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rxd_s1_q   <= 1'b1;
         rxd_s2_q   <= 1'b1;
         rxd_prev_q <= 1'b1;
      end else begin
         rxd_s1_q   <= console_rxd;
         rxd_s2_q   <= rxd_s1_q;
         rxd_prev_q <= rxd_s2_q;
      end
   end

   // ---------------- RX FSM ----------------
   rx_state_t            rx_state_q, rx_state_d;
   logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
   logic [BW-1:0]        rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
   logic                 rx_tick, rx_push_req, frame_err_set;

   assign rx_tick = (rx_cnt_q == CW'(DIVISOR - 1));

   // RX next state: confirm the start bit at mid-bit, then sample data and stop one bit time apart
   always_comb begin
      rx_state_d    = rx_state_q;
      rx_cnt_d      = rx_cnt_q;
      rx_bit_d      = rx_bit_q;
      rx_shift_d    = rx_shift_q;
      rx_push_req   = 1'b0;
      frame_err_set = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            // The detection cycle already counts toward the half-bit wait
            if (rxd_prev_q && !rxd_s2_q) begin
               rx_cnt_d   = CW'(1);
               rx_state_d = RX_START_CHK;
            end
         end
         RX_START_CHK: begin
            if (rx_cnt_q == CW'(DIVISOR / 2 - 1)) begin
               rx_cnt_d = '0;
               rx_bit_d = '0;
               rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (rx_tick) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rxd_s2_q, rx_shift_q[DATA_BITS-1:1]};
               if (rx_bit_q == BW'(DATA_BITS - 1)) rx_state_d = RX_STOP;
               else                                rx_bit_d   = rx_bit_q + 1'b1;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_tick) begin
               rx_cnt_d = '0;
               if (rxd_s2_q) begin
                  rx_push_req = 1'b1;
                  rx_state_d  = RX_IDLE;
               end else begin
                  frame_err_set = 1'b1;
                  rx_state_d    = RX_WAIT_HIGH;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_WAIT_HIGH: begin
            // A held-low line (break) must not retrigger a new character
            if (rxd_s2_q) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // RX state registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
      end
   end

   assign rx_state_dbg = rx_state_q;

   // ---------------- RX FIFO ----------------
   logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
   logic [RAW:0]         rx_wr_q, rx_rd_q, rx_rd_inc;
   logic                 rx_empty, rx_full, rx_pop, rx_push, overrun_set;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 framing_q, framing_d, overrun_q, overrun_d;

   assign rx_empty    = (rx_wr_q == rx_rd_q);
   assign rx_full     = (rx_wr_q[RAW] != rx_rd_q[RAW]) && (rx_wr_q[RAW-1:0] == rx_rd_q[RAW-1:0]);
   assign rx_rd_inc   = rx_rd_q + 1'b1;
   assign rx_pop      = rx_read && !rx_empty;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts the character
   assign rx_push     = rx_push_req && (!rx_full || rx_pop);
   assign overrun_set = rx_push_req && rx_full && !rx_pop;

   // Registered head: follows the next entry after a pop, or the first character into an empty FIFO
   always_comb begin
      rx_data_d = rx_data_q;
      if (rx_pop) begin
         if (rx_rd_inc != rx_wr_q) rx_data_d = rx_mem[rx_rd_inc[RAW-1:0]];
         else if (rx_push)         rx_data_d = rx_shift_q;
      end else if (rx_empty && rx_push) begin
         rx_data_d = rx_shift_q;
      end
      framing_d = frame_err_set ? 1'b1 : (err_clear ? 1'b0 : framing_q);
      overrun_d = overrun_set   ? 1'b1 : (err_clear ? 1'b0 : overrun_q);
   end

   // RX FIFO storage
   always_ff @(posedge clock) begin
      if (rx_push) rx_mem[rx_wr_q[RAW-1:0]] <= rx_shift_q;
   end

   // RX FIFO pointers, head register and sticky error flags
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_wr_q   <= '0;
         rx_rd_q   <= '0;
         rx_data_q <= '0;
         framing_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
         if (rx_pop)  rx_rd_q <= rx_rd_inc;
         rx_data_q <= rx_data_d;
         framing_q <= framing_d;
         overrun_q <= overrun_d;
      end
   end

   assign rx_data        = rx_data_q;
   assign rx_valid       = !rx_empty;
   assign rx_framing_err = framing_q;
   assign rx_overrun     = overrun_q;

endmodule

// File: tb/tb_console_uart.sv
// Bench for console_uart: an 8-bit instance with switchable loopback and a 7-bit receive instance.
module tb_console_uart;

   localparam int D = 4;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   // ---------------- 8-bit instance ----------------
   logic [7:0] tx_data, rx_data;
   logic       tx_write, tx_full, tx_idle, rx_read, rx_valid;
   logic       rx_framing_err, rx_overrun, err_clear, console_rxd, console_txd;
   logic [1:0] tx_state_dbg;
   logic [2:0] rx_state_dbg;
   logic       loop_en, drive_rxd;

   assign console_rxd = loop_en ? console_txd : drive_rxd;

   console_uart #(.DIVISOR(D), .DATA_BITS(8), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
      .clock(clock), .reset(reset), .tx_data(tx_data), .tx_write(tx_write),
      .tx_full(tx_full), .tx_idle(tx_idle), .rx_data(rx_data), .rx_read(rx_read),
      .rx_valid(rx_valid), .rx_framing_err(rx_framing_err), .rx_overrun(rx_overrun),
      .err_clear(err_clear), .console_rxd(console_rxd), .console_txd(console_txd),
      .tx_state_dbg(tx_state_dbg), .rx_state_dbg(rx_state_dbg)
   );

   // ---------------- 7-bit instance ----------------
   logic [6:0] tx_data7, rx_data7;
   logic       tx_write7, tx_full7, tx_idle7, rx_read7, rx_valid7;
   logic       rx_fe7, rx_ov7, err_clear7, drive_rxd7, txd7;
   logic [1:0] tx_dbg7;
   logic [2:0] rx_dbg7;

   console_uart #(.DIVISOR(D), .DATA_BITS(7), .TX_DEPTH(2), .RX_DEPTH(2)) dut7 (
      .clock(clock), .reset(reset), .tx_data(tx_data7), .tx_write(tx_write7),
      .tx_full(tx_full7), .tx_idle(tx_idle7), .rx_data(rx_data7), .rx_read(rx_read7),
      .rx_valid(rx_valid7), .rx_framing_err(rx_fe7), .rx_overrun(rx_ov7),
      .err_clear(err_clear7), .console_rxd(drive_rxd7), .console_txd(txd7),
      .tx_state_dbg(tx_dbg7), .rx_state_dbg(rx_dbg7)
   );

   // ---------------- scoreboard state ----------------
   logic [7:0] exp_q[$];
   logic [6:0] exp7_q[$];
   logic [0:0] tx_exp_q[$];
   int         n_vec  = 0;
   int         n_miss = 0;
   logic       auto_read, force_read, tx_busy;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitors ----------------
   task automatic mon_rx();
      forever begin
         @(negedge clock);
         rx_read = force_read;
         if (auto_read && rx_valid) begin
            if (exp_q.size() == 0) check("rx_unexpected_char", {31'd0, rx_valid}, 32'd0);
            else                   check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            rx_read = 1'b1;
         end
      end
   endtask

   task automatic mon_rx7();
      forever begin
         @(negedge clock);
         rx_read7 = 1'b0;
         if (rx_valid7) begin
            if (exp7_q.size() == 0) check("rx7_unexpected_char", {31'd0, rx_valid7}, 32'd0);
            else                    check("rx7_data", {25'd0, rx_data7}, {25'd0, exp7_q.pop_front()});
            rx_read7 = 1'b1;
         end
      end
   endtask

   task automatic mon_tx();
      logic [0:0] e;
      forever begin
         @(negedge clock);
         if (tx_exp_q.size() > 0 && (tx_busy || console_txd == 1'b0)) begin
            tx_busy = 1'b1;
            e = tx_exp_q.pop_front();
            check("txd_bit", {31'd0, console_txd}, {31'd0, e});
            if (tx_exp_q.size() == 0) tx_busy = 1'b0;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic push_tx_frame(input logic [7:0] d);
      repeat (D) tx_exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) repeat (D) tx_exp_q.push_back(d[i]);
      repeat (D) tx_exp_q.push_back(1'b1);
   endtask

   task automatic write_char(input logic [7:0] d, input bit sent);
      @(negedge clock);
      tx_data  = d;
      tx_write = 1'b1;
      if (sent) push_tx_frame(d);
   endtask

   task automatic set_pin(input bit to7, input logic b);
      if (to7) drive_rxd7 = b;
      else     drive_rxd  = b;
   endtask

   task automatic drive_frame(input logic [7:0] d, input int nbits, input logic stop_bit, input bit to7);
      @(negedge clock);
      set_pin(to7, 1'b0);
      repeat (D) @(negedge clock);
      for (int i = 0; i < nbits; i++) begin
         set_pin(to7, d[i]);
         repeat (D) @(negedge clock);
      end
      set_pin(to7, stop_bit);
      repeat (D) @(negedge clock);
      set_pin(to7, 1'b1);
      repeat (2 * D) @(negedge clock);
   endtask

   task automatic wait_tx_idle(input int budget, input string name);
      int n = 0;
      while (!(tx_idle && tx_exp_q.size() == 0) && n < budget) begin
         @(negedge clock);
         n++;
      end
      check(name, {31'd0, tx_idle}, 32'd1);
      repeat (10) @(negedge clock);
   endtask

   task automatic pulse_err_clear();
      @(negedge clock);
      err_clear = 1'b1;
      @(negedge clock);
      err_clear = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int         lows;
      int         n;
      logic [7:0] v;
      tx_data = '0; tx_write = 0; rx_read = 0; err_clear = 0;
      loop_en = 0; drive_rxd = 1; auto_read = 0; force_read = 0; tx_busy = 0;
      tx_data7 = '0; tx_write7 = 0; rx_read7 = 0; err_clear7 = 0; drive_rxd7 = 1;

      // Reset values
      repeat (3) @(negedge clock);
      check("rst_txd", {31'd0, console_txd}, 32'd1);
      check("rst_tx_full", {31'd0, tx_full}, 32'd0);
      check("rst_tx_idle", {31'd0, tx_idle}, 32'd1);
      check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_rx_data", {24'd0, rx_data}, 32'd0);
      check("rst_framing", {31'd0, rx_framing_err}, 32'd0);
      check("rst_overrun", {31'd0, rx_overrun}, 32'd0);
      check("rst_txd7", {31'd0, txd7}, 32'd1);
      reset = 1'b0;
      fork
         mon_rx();
         mon_rx7();
         mon_tx();
      join_none
      repeat (2) @(negedge clock);

      // Single 0x55 frame: start latency and frame length
      write_char(8'h55, 1'b1);
      @(negedge clock);
      tx_write = 1'b0;
      check("tx_before_start", {31'd0, console_txd}, 32'd1);
      check("tx_idle_queued", {31'd0, tx_idle}, 32'd0);
      @(negedge clock);
      check("tx_start_latency", {31'd0, console_txd}, 32'd0);
      repeat (39) @(negedge clock);
      check("tx_idle_in_stop", {31'd0, tx_idle}, 32'd0);
      @(negedge clock);
      check("tx_idle_after_frame", {31'd0, tx_idle}, 32'd1);
      check("txd_idle_high", {31'd0, console_txd}, 32'd1);

      // Loopback of three back-to-back characters
      loop_en = 1'b1;
      auto_read = 1'b1;
      exp_q.push_back(8'hA3); exp_q.push_back(8'h0F); exp_q.push_back(8'hFF);
      write_char(8'hA3, 1'b1);
      write_char(8'h0F, 1'b1);
      write_char(8'hFF, 1'b1);
      @(negedge clock);
      tx_write = 1'b0;
      wait_tx_idle(400, "loop_tx_done");
      check("loop_rx_left", exp_q.size(), 32'd0);
      check("loop_framing", {31'd0, rx_framing_err}, 32'd0);
      check("loop_overrun", {31'd0, rx_overrun}, 32'd0);

      // TX FIFO full / dropped write, RX overrun with no reads
      auto_read = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (i == 4) check("tx_full_at_3", {31'd0, tx_full}, 32'd0);
         if (i == 5) check("tx_full_at_4", {31'd0, tx_full}, 32'd1);
         v = 8'(17 * (i + 1));
         tx_data  = v;
         tx_write = 1'b1;
         if (i < 5) push_tx_frame(v);
         if (i < 4) exp_q.push_back(v);
      end
      @(negedge clock);
      check("tx_full_hold", {31'd0, tx_full}, 32'd1);
      tx_write = 1'b0;
      wait_tx_idle(400, "burst_tx_done");
      check("overrun_set", {31'd0, rx_overrun}, 32'd1);
      check("overrun_valid", {31'd0, rx_valid}, 32'd1);
      check("overrun_no_framing", {31'd0, rx_framing_err}, 32'd0);
      check("overrun_head", {24'd0, rx_data}, 32'h11);
      auto_read = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(negedge clock);
         n++;
      end
      repeat (3) @(negedge clock);
      check("overrun_drained", {31'd0, rx_valid}, 32'd0);
      check("overrun_sticky", {31'd0, rx_overrun}, 32'd1);
      pulse_err_clear();
      check("overrun_cleared", {31'd0, rx_overrun}, 32'd0);
      force_read = 1'b1;
      repeat (2) @(negedge clock);
      force_read = 1'b0;
      @(negedge clock);
      check("read_empty_ignored", {31'd0, rx_valid}, 32'd0);

      // Framing error then a good character
      loop_en = 1'b0;
      drive_rxd = 1'b1;
      drive_frame(8'h41, 8, 1'b0, 1'b0);
      repeat (10) @(negedge clock);
      check("framing_set", {31'd0, rx_framing_err}, 32'd1);
      check("framing_no_char", {31'd0, rx_valid}, 32'd0);
      exp_q.push_back(8'h42);
      drive_frame(8'h42, 8, 1'b1, 1'b0);
      repeat (10) @(negedge clock);
      check("after_framing_rx_left", exp_q.size(), 32'd0);
      check("framing_sticky", {31'd0, rx_framing_err}, 32'd1);
      pulse_err_clear();
      check("framing_cleared", {31'd0, rx_framing_err}, 32'd0);

      // One-cycle low glitch
      @(negedge clock);
      drive_rxd = 1'b0;
      @(negedge clock);
      drive_rxd = 1'b1;
      repeat (60) @(negedge clock);
      check("glitch_no_char", {31'd0, rx_valid}, 32'd0);
      check("glitch_no_framing", {31'd0, rx_framing_err}, 32'd0);

      // 7-bit instance
      exp7_q.push_back(7'h7F);
      exp7_q.push_back(7'h2A);
      drive_frame(8'h7F, 7, 1'b1, 1'b1);
      drive_frame(8'h2A, 7, 1'b1, 1'b1);
      repeat (10) @(negedge clock);
      check("rx7_left", exp7_q.size(), 32'd0);
      check("rx7_framing", {31'd0, rx_fe7}, 32'd0);

      // Reset in the middle of a TX frame, loopback on
      loop_en = 1'b1;
      write_char(8'h5A, 1'b0);
      write_char(8'hC3, 1'b0);
      @(negedge clock);
      tx_write = 1'b0;
      @(negedge clock);
      check("tx_mid_frame_low", {31'd0, console_txd}, 32'd0);
      #1;
      reset = 1'b1;
      #1;
      check("reset_async_txd", {31'd0, console_txd}, 32'd1);
      check("reset_tx_idle", {31'd0, tx_idle}, 32'd1);
      check("reset_tx_full", {31'd0, tx_full}, 32'd0);
      check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      lows = 0;
      repeat (120) begin
         @(negedge clock);
         if (!console_txd) lows++;
      end
      check("queued_chars_lost", lows, 32'd0);
      check("reset_partial_rx", {31'd0, rx_valid}, 32'd0);
      check("reset_no_framing", {31'd0, rx_framing_err}, 32'd0);

      // Nothing left outstanding
      check("end_rx_q", exp_q.size(), 32'd0);
      check("end_rx7_q", exp7_q.size(), 32'd0);
      check("end_tx_q", tx_exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
